cordic_iter_engine: RTL and testbench

- Iterative, parametrised CORDIC core. It runs one micro-rotation per clock, reusing a single add/sub datapath, and supports both rotation and vectoring modes.
- Optional sequential gain compensation multiplies the results by K ≈ 0.6072529 using a bit-serial shift-add over the set bits of K.
- Sits between the TinyTapeout I/O wrapper and the operand registers.
- Valid/ready handshake on both input and output.

---
 rtl/cordic_iter_engine_pkg.sv | 42 ++++
 rtl/cordic_iter_engine_microrot.sv | 29 ++
 rtl/cordic_iter_engine.sv | 154 +++++++++++++++
 tb/tb_cordic_iter_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_iter_engine_pkg.sv
// Shared types and elaboration-time helpers for the iterative CORDIC engine.
package cordic_iter_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROT   = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] K_CONST_DEFAULT = 16'h9B75;

  // pi scaled by 2^60; the arctangent series below uses the same scale
  localparam longint PI_Q60 = 64'sd3622009729038561421;

  // round(atan(2^-i)/pi * 2^(width-1)), via the Taylor series of atan in Q60
  function automatic int atan_ba(input int i, input int width);
    longint acc;
    longint term;
    longint den;
    if (i == 0) return 1 << (width - 3);
    acc = 0;
    for (int k = 1; i * k <= 60; k += 2) begin
      term = (longint'(1) << (60 - i * k)) / longint'(k);
      if ((((k - 1) / 2) % 2) == 0) acc = acc + term;
      else acc = acc - term;
    end
    den = PI_Q60 >>> (width - 1);
    return int'((acc + den / 2) / den);
  endfunction

  function automatic longint saturate(input longint v, input int width);
    longint hi;
    longint lo;
    hi = (longint'(1) << (width - 1)) - 1;
    lo = -(longint'(1) << (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cordic_iter_engine_microrot.sv
// One combinational CORDIC micro-rotation; the caller registers the results.
module cordic_iter_engine_microrot #(
  parameter int WIDTH = 16,
  parameter int IW    = WIDTH + 2,
  parameter int CW    = 4
) (
  input  logic signed [IW-1:0]    x,
  input  logic signed [IW-1:0]    y,
  input  logic signed [WIDTH-1:0] z,
  input  logic [CW-1:0]           i,
  input  logic                    d,
  input  logic signed [WIDTH-1:0] atan,
  output logic signed [IW-1:0]    x_next,
  output logic signed [IW-1:0]    y_next,
  output logic signed [WIDTH-1:0] z_next
);

  logic signed [IW-1:0] x_sh;
  logic signed [IW-1:0] y_sh;

  assign x_sh = x >>> i;
  assign y_sh = y >>> i;

  // d = 1 selects the +1 direction; z wraps naturally at WIDTH bits
  assign x_next = d ? (x - y_sh) : (x + y_sh);
  assign y_next = d ? (y + x_sh) : (y - x_sh);
  assign z_next = d ? (z - atan) : (z + atan);

endmodule

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC: one micro-rotation per clock, then optional bit-serial
// multiply by K, with valid/ready on both sides.
module cordic_iter_engine
  import cordic_iter_engine_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITERS = 14,
  parameter int COMP  = 1,
  parameter logic [WIDTH-1:0] K_CONST = WIDTH'(K_CONST_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);

  localparam int IW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH);
  localparam int NT = 2 ** CW;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   mode_r;
  logic signed [IW-1:0]   x_r;
  logic signed [IW-1:0]   y_r;
  logic signed [WIDTH-1:0] z_r;
  logic signed [IW-1:0]   ax;
  logic signed [IW-1:0]   ay;

  logic signed [WIDTH-1:0] atan_tab [NT];
  logic signed [WIDTH-1:0] atan_cur;
  logic                    d;
  logic signed [IW-1:0]    x_nx;
  logic signed [IW-1:0]    y_nx;
  logic signed [WIDTH-1:0] z_nx;

  logic [CW:0]             sh;
  logic [CW-1:0]           kidx;
  logic                    k_bit;
  logic signed [IW-1:0]    ax_nx;
  logic signed [IW-1:0]    ay_nx;

  for (genvar g = 0; g < NT; g++) begin : g_atan
    localparam int A = (g < ITERS) ? atan_ba(g, WIDTH) : 0;
    assign atan_tab[g] = WIDTH'(A);
  end

  assign atan_cur = atan_tab[cnt];
  assign d        = mode_r ? y_r[IW-1] : ~z_r[WIDTH-1];

  cordic_iter_engine_microrot #(
    .WIDTH (WIDTH),
    .IW    (IW),
    .CW    (CW)
  ) u_microrot (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .i      (cnt),
    .d      (d),
    .atan   (atan_cur),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

  // Bit j of the scale pass weighs K's bit WIDTH-1-j with a shift of j+1
  assign sh    = {1'b0, cnt} + 1'b1;
  assign kidx  = CW'(WIDTH - 1) - cnt;
  assign k_bit = K_CONST[kidx];
  assign ax_nx = k_bit ? (ax + (x_r >>> sh)) : ax;
  assign ay_nx = k_bit ? (ay + (y_r >>> sh)) : ay;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      cnt       <= '0;
      mode_r    <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      ax        <= '0;
      ay        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            mode_r   <= mode;
            x_r      <= {{2{x_in[WIDTH-1]}}, x_in};
            y_r      <= {{2{y_in[WIDTH-1]}}, y_in};
            z_r      <= z_in;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= S_ROT;
          end
        end
        S_ROT: begin
          x_r <= x_nx;
          y_r <= y_nx;
          z_r <= z_nx;
          if (cnt == CW'(ITERS - 1)) begin
            cnt   <= '0;
            ax    <= '0;
            ay    <= '0;
            state <= (COMP != 0) ? S_SCALE : S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SCALE: begin
          if (cnt == CW'(WIDTH - 1)) begin
            x_r   <= ax_nx;
            y_r   <= ay_nx;
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            ax  <= ax_nx;
            ay  <= ay_nx;
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          // First DONE cycle registers the saturated result; later cycles hold it
          if (!out_valid) begin
            x_out     <= WIDTH'(saturate(longint'(x_r), WIDTH));
            y_out     <= WIDTH'(saturate(longint'(y_r), WIDTH));
            z_out     <= z_r;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench: one engine with gain compensation, one without, sharing operand buses.
module tb_cordic_iter_engine;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic mode;
  logic signed [W-1:0] x_in, y_in, z_in;
  logic in_valid [2];
  logic in_ready [2];
  logic out_valid [2];
  logic out_ready [2];
  logic signed [W-1:0] xo [2];
  logic signed [W-1:0] yo [2];
  logic signed [W-1:0] zo [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_iter_engine #(.WIDTH(16), .ITERS(14), .COMP(0)) u_raw (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .x_out(xo[0]), .y_out(yo[0]), .z_out(zo[0])
  );

  cordic_iter_engine #(.WIDTH(16), .ITERS(14), .COMP(1)) u_comp (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .x_out(xo[1]), .y_out(yo[1]), .z_out(zo[1])
  );

  typedef struct {
    string name;
    int    comp;
    bit    md;
    int    x, y, z;
    int    ex, ey, ez;
    int    tx, ty, tz;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    int diff;
    diff = act - exp;
    checks++;
    if (diff > tol || diff < -tol) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic check_angle(input string name, input int act, input int exp, input int tol);
    logic signed [15:0] dw;
    int diff;
    dw = 16'(act - exp);
    diff = int'(dw);
    checks++;
    if (diff > tol || diff < -tol) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d +/- %0d (mod 2^16)", name, act, exp, tol);
    end
  endtask

  task automatic wait_valid(input int c, output int lat);
    lat = 0;
    while (out_valid[c] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take(input int c, input string name);
    out_ready[c] = 1'b1;
    @(posedge clk); #1;
    out_ready[c] = 1'b0;
    check_near({name, ".ov_after_take"}, int'(out_valid[c]), 0, 0);
    check_near({name, ".ir_after_take"}, int'(in_ready[c]), 1, 0);
  endtask

  task automatic drive_ops(input bit md, input int xv, input int yv, input int zv);
    mode = md;
    x_in = 16'(xv);
    y_in = 16'(yv);
    z_in = 16'(zv);
  endtask

  task automatic apply_vec(input vec_t v);
    int lat;
    int c;
    c = v.comp;
    check_near({v.name, ".idle"}, int'(in_ready[c]), 1, 0);
    drive_ops(v.md, v.x, v.y, v.z);
    in_valid[c] = 1'b1;
    @(posedge clk); #1;
    in_valid[c] = 1'b0;
    check_near({v.name, ".busy"}, int'(in_ready[c]), 0, 0);
    wait_valid(c, lat);
    check_near({v.name, ".latency"}, lat, (c == 1) ? 31 : 15, 0);
    check_near({v.name, ".x"}, int'(xo[c]), v.ex, v.tx);
    check_near({v.name, ".y"}, int'(yo[c]), v.ey, v.ty);
    check_angle({v.name, ".z"}, int'(zo[c]), v.ez, v.tz);
    take(c, v.name);
  endtask

  initial begin
    int lat;
    int changes;
    int extra;
    logic signed [W-1:0] sx, sy, sz;

    // Compensated results carry a small downward bias: every set bit of K
    // contributes one truncating shift, so tolerances there are wider.
    vecs[0] = '{"rot45",    1, 1'b0,   8192,     0,  8192,   5793,  5793,    0, 12, 12, 3};
    vecs[1] = '{"vec45",    1, 1'b1,   8192,  8192,     0,  11585,     0, 8192, 12, 12, 3};
    vecs[2] = '{"rotm45",   1, 1'b0,   8192,     0, -8192,   5793, -5793,    0, 12, 12, 3};
    vecs[3] = '{"rot90",    1, 1'b0,      0,  8192, 16384,  -8192,     0,    0, 12, 12, 3};
    vecs[4] = '{"raw0",     0, 1'b0,   8192,     0,     0,  13490,     0,    0,  6,  6, 3};
    vecs[5] = '{"sat_pos",  0, 1'b1,  16383, 16383,     0,  32767,     0, 8192,  0, 10, 4};
    vecs[6] = '{"sat_neg",  0, 1'b0, -16383, 16383,  8192, -32768,     0,    0,  0, 10, 3};

    rst = 1'b1;
    drive_ops(1'b0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      in_valid[c] = 1'b0;
      out_ready[c] = 1'b0;
    end
    #12;
    for (int c = 0; c < 2; c++) begin
      check_near("reset.in_ready", int'(in_ready[c]), 1, 0);
      check_near("reset.out_valid", int'(out_valid[c]), 0, 0);
      check_near("reset.x_out", int'(xo[c]), 0, 0);
      check_near("reset.y_out", int'(yo[c]), 0, 0);
      check_near("reset.z_out", int'(zo[c]), 0, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < NV; n++) apply_vec(vecs[n]);

    // Back-pressure: result must hold untouched while out_ready stays low
    drive_ops(1'b1, 8192, 8192, 0);
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    wait_valid(1, lat);
    check_near("bp.latency", lat, 31, 0);
    sx = xo[1]; sy = yo[1]; sz = zo[1];
    changes = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid[1] !== 1'b1 || in_ready[1] !== 1'b0 ||
          xo[1] !== sx || yo[1] !== sy || zo[1] !== sz) changes++;
    end
    check_near("bp.hold_changes", changes, 0, 0);
    check_near("bp.x", int'(xo[1]), 11585, 12);
    take(1, "bp");

    // Asynchronous reset in the middle of the rotation phase
    drive_ops(1'b0, 8192, 0, 8192);
    in_valid[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check_near("abort.busy_before", int'(in_ready[1]), 0, 0);
    #2 rst = 1'b1;
    #1;
    check_near("abort.in_ready", int'(in_ready[1]), 1, 0);
    check_near("abort.out_valid", int'(out_valid[1]), 0, 0);
    check_near("abort.x_out", int'(xo[1]), 0, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    apply_vec(vecs[0]);

    // in_valid held high while busy must not start a second operation
    drive_ops(1'b0, 8192, 0, 0);
    in_valid[0] = 1'b1;
    @(posedge clk); #1;
    drive_ops(1'b0, -8000, 3000, 4000);
    lat = 0;
    repeat (10) begin @(posedge clk); #1; lat++; end
    in_valid[0] = 1'b0;
    check_near("busy.ir_while_busy", int'(in_ready[0]), 0, 0);
    begin
      int more;
      wait_valid(0, more);
      lat = lat + more;
    end
    check_near("busy.latency", lat, 15, 0);
    check_near("busy.x", int'(xo[0]), 13490, 6);
    check_near("busy.y", int'(yo[0]), 0, 6);
    take(0, "busy");
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid[0] !== 1'b0) extra++;
    end
    check_near("busy.extra_valid", extra, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
